// File: rtl/outsched_pkg.sv
// rtl/outsched_pkg.sv - shared types and helpers for the output scheduler
package outsched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        CAPT,
        SEND,
        DONE
    } sched_state_e;

    localparam int OUTSCHED_TIMEOUT_DEFAULT = 1024;

    function automatic int pid_width(input int nprocess);
        return (nprocess > 1) ? $clog2(nprocess) : 1;
    endfunction

    function automatic int len_width(input int addr_width);
        return $clog2(addr_width) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
    import outsched_pkg::*;
#(
    parameter int NPROCESS  = 11,
    parameter int PID_WIDTH = pid_width(NPROCESS)
) (
    input  logic [NPROCESS-1:0]  i_req,
    input  logic [PID_WIDTH-1:0] i_last,
    output logic [NPROCESS-1:0]  o_grant,
    output logic [PID_WIDTH-1:0] o_pid
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_pid   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NPROCESS; i++) begin
            if (!w_found && i_req[(int'(i_last) + i) % NPROCESS]) begin
                w_found = 1'b1;
                o_grant[(int'(i_last) + i) % NPROCESS] = 1'b1;
                o_pid = PID_WIDTH'((int'(i_last) + i) % NPROCESS);
            end
        end
    end

endmodule

// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - round-robin flush sequencer from output memory to display sink
// Optional send timeout enabled by OUTSCHED_TIMEOUT_EN.
module output_scheduler
    import outsched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 1024,
    parameter int NPROCESS   = 11,
    parameter int PID_WIDTH  = pid_width(NPROCESS),
    parameter int LEN_WIDTH  = len_width(ADDR_WIDTH)
`ifdef OUTSCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = OUTSCHED_TIMEOUT_DEFAULT
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_req,
    input  logic [PID_WIDTH-1:0]  flush_pid,
    input  logic [LEN_WIDTH-1:0]  flush_len,
    output logic [NPROCESS-1:0]   pending,
    output logic                  flush_done,
    output logic [PID_WIDTH-1:0]  done_pid,
    output logic                  auto,
    output logic [DATA_WIDTH-1:0] adress,
    output logic [DATA_WIDTH-1:0] ReadpId,
    output logic                  out,
    input  logic [DATA_WIDTH-1:0] dataout,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic [PID_WIDTH-1:0]  disp_pid,
    input  logic                  disp_ready,
    output logic                  timeout_err
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(ADDR_WIDTH);

    sched_state_e          r_state;
    sched_state_e          w_next_state;
    logic [NPROCESS-1:0]   r_pending;
    logic [LEN_WIDTH-1:0]  r_len [NPROCESS];
    logic [PID_WIDTH-1:0]  r_rr_ptr;
    logic [PID_WIDTH-1:0]  r_cur_pid;
    logic [LEN_WIDTH-1:0]  r_cur_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_adress;
    logic [DATA_WIDTH-1:0] r_readpid;
    logic [DATA_WIDTH-1:0] r_disp_data;
    logic [PID_WIDTH-1:0]  r_disp_pid;

    logic [NPROCESS-1:0]   w_grant;
    logic [PID_WIDTH-1:0]  w_grant_pid;
    logic                  w_flush_ok;
    logic [LEN_WIDTH-1:0]  w_clamped;
    logic [NPROCESS-1:0]   w_set;
    logic [NPROCESS-1:0]   w_clr;
    logic [LEN_WIDTH-1:0]  w_cnt_inc;
    logic                  w_timeout;
    logic                  w_advance;

    rr_arbiter #(
        .NPROCESS  (NPROCESS),
        .PID_WIDTH (PID_WIDTH)
    ) u_arb (
        .i_req   (r_pending),
        .i_last  (r_rr_ptr),
        .o_grant (w_grant),
        .o_pid   (w_grant_pid)
    );

    // The pending bit doubles as the duplicate filter, including during DONE
    assign w_flush_ok = flush_req && (int'(flush_pid) < NPROCESS) && !r_pending[flush_pid];
    assign w_clamped  = (flush_len > MAX_LEN) ? MAX_LEN : flush_len;
    assign w_set      = w_flush_ok ? (NPROCESS'(1) << flush_pid) : '0;
    assign w_clr      = (r_state == DONE) ? (NPROCESS'(1) << r_cur_pid) : '0;
    assign w_cnt_inc  = r_cnt + LEN_WIDTH'(1);
    assign w_advance  = (r_state == SEND) && (disp_ready || w_timeout);

`ifdef OUTSCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    assign w_timeout   = (r_state == SEND) && !disp_ready &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == SEND && !disp_ready && !w_timeout)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;
            if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (|r_pending) w_next_state = ARB;
            ARB: begin
                if (|w_grant)
                    w_next_state = (r_len[w_grant_pid] == '0) ? DONE : ISSUE;
                else
                    w_next_state = IDLE;
            end
            ISSUE: w_next_state = CAPT;
            CAPT:  w_next_state = SEND;
            SEND: begin
                if (w_advance)
                    w_next_state = (w_cnt_inc == r_cur_len) ? DONE : ISSUE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_rr_ptr    <= PID_WIDTH'(NPROCESS - 1);
            r_cur_pid   <= '0;
            r_cur_len   <= '0;
            r_cnt       <= '0;
            r_adress    <= '0;
            r_readpid   <= '0;
            r_disp_data <= '0;
            r_disp_pid  <= '0;
            for (int i = 0; i < NPROCESS; i++)
                r_len[i] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_flush_ok)
                r_len[flush_pid] <= w_clamped;
            case (r_state)
                ARB: begin
                    if (|w_grant) begin
                        r_cur_pid <= w_grant_pid;
                        r_rr_ptr  <= w_grant_pid;
                        r_cur_len <= r_len[w_grant_pid];
                        r_cnt     <= '0;
                        if (r_len[w_grant_pid] != '0) begin
                            r_adress  <= '0;
                            r_readpid <= DATA_WIDTH'(w_grant_pid);
                        end
                    end
                end
                CAPT: begin
                    r_disp_data <= dataout;
                    r_disp_pid  <= r_cur_pid;
                end
                SEND: begin
                    if (w_advance) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc != r_cur_len)
                            r_adress <= DATA_WIDTH'(w_cnt_inc);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pending    = r_pending;
    assign auto       = (r_state == ISSUE);
    assign out        = (r_state != IDLE);
    assign disp_valid = (r_state == SEND);
    assign flush_done = (r_state == DONE);
    assign done_pid   = flush_done ? r_cur_pid : '0;
    assign adress     = r_adress;
    assign ReadpId    = r_readpid;
    assign disp_data  = r_disp_data;
    assign disp_pid   = r_disp_pid;

endmodule

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Sequences reads from the per-process output memory (NPROCESS regions of ADDR_WIDTH words) and streams them to a display/console sink over a valid/ready handshake.
- Processes post flush requests (pid, word count); the scheduler services pending flushes round-robin.
- For each word it drives ReadpId/adress, pulses the memory's `auto` read strobe, captures `dataout`, then hands the word to the sink.

Parameters:
- DATA_WIDTH, 32, width of data, address and pid buses toward the output memory.
- ADDR_WIDTH, 1024, words per process region.
- NPROCESS, 11, number of process regions.
- PID_WIDTH, 4, internal pid width (clog2(NPROCESS)).
- LEN_WIDTH, 11, flush length width (clog2(ADDR_WIDTH)+1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush_req  in  1  one-cycle flush request.
- flush_pid  in  PID_WIDTH  process requesting flush.
- flush_len  in  LEN_WIDTH  words to emit, starting at region address 0.
- pending  out  NPROCESS  bitmap of accepted, not yet completed flushes (includes the active one).
- flush_done  out  1  one-cycle pulse when a flush completes.
- done_pid  out  PID_WIDTH  pid of completed flush, valid with flush_done.
- auto  out  1  read strobe to the output memory.
- adress  out  DATA_WIDTH  read word address within the region.
- ReadpId  out  DATA_WIDTH  region select (zero-extended pid).
- out  out  1  memory output mux select; 1 whenever a flush is active.
- dataout  in  DATA_WIDTH  memory read data.
- disp_valid  out  1  word available to sink.
- disp_data  out  DATA_WIDTH  word to sink.
- disp_pid  out  PID_WIDTH  owning pid of disp_data.
- disp_ready  in  1  sink accepts the word.
- timeout_err  out  1  sticky error (see Optional Feature).

Behaviour:
- Reset (async, active-high):
  - Outputs: all outputs 0; disp_data = 0.
  - Internal state: pending cleared, per-pid length array cleared, round-robin pointer = NPROCESS-1 (so pid 0 wins first), state = IDLE.
- Flush accept (every cycle, any state):
  - flush_req && flush_pid < NPROCESS && !pending[flush_pid]: set the pending bit and store the length, clamped to ADDR_WIDTH.
  - A request that is out of range or targets an already-pending pid is dropped silently.
- FSM states: IDLE, ARB, ISSUE, CAPT, SEND, DONE.
- IDLE: if pending != 0, go to ARB.
- ARB:
  - Pick the first pending pid searching from rr_ptr+1 modulo NPROCESS; latch it as cur_pid; set rr_ptr = cur_pid; word counter = 0.
  - If the stored length is 0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Drive ReadpId = cur_pid and adress = counter, registered and stable from ARB/SEND exit; drive auto = 1 for exactly this one cycle.
  - Go to CAPT.
- CAPT:
  - auto = 0; register dataout into disp_data; disp_pid = cur_pid.
  - Go to SEND with disp_valid = 1.
- SEND:
  - Hold disp_valid, disp_data and disp_pid stable until disp_ready is sampled high.
  - On handshake: disp_valid = 0, counter++.
  - If counter == len: go to DONE; else go to ISSUE.
  - Throughput: at most one word per 3 cycles.
- DONE:
  - Pulse flush_done = 1 with done_pid = cur_pid; clear pending[cur_pid]; go to IDLE.
  - A new flush_req for the same pid in this cycle is dropped, because the bit is still set.
- out = 1 in states ARB through DONE, 0 in IDLE.
- adress and ReadpId hold their last value when not in use.
- Counter width is LEN_WIDTH; adress is the counter zero-extended.
- Reset mid-flush: abort immediately; no flush_done for the aborted pid; all pending flushes are lost.

Optional Feature:
- Macro: OUTSCHED_TIMEOUT_EN (parameter TIMEOUT_CYCLES, default 1024).
- With the macro: a counter runs while in SEND with disp_ready low. When it reaches TIMEOUT_CYCLES, the word is dropped, the FSM proceeds as if the handshake occurred, and timeout_err is set. timeout_err is sticky and cleared only by reset.
- Without the macro: SEND waits indefinitely and timeout_err is tied to 0.

Decomposition:
- Package outsched_pkg holds:
  - the state enum (IDLE..DONE);
  - PID_WIDTH and LEN_WIDTH helper functions (clog2);
  - the default TIMEOUT_CYCLES constant.
- Sub-module rr_arbiter (NPROCESS-wide): inputs req bitmap and last-grant pointer; outputs a one-hot grant plus an encoded pid. Combinational pick only; the pointer stays registered in the scheduler.

Test Plan:
- Single flush: pid 3, len 2, preloaded mem[3*1024+0]=0xA, [3*1024+1]=0xB, disp_ready = 1.
  - Required: exactly 2 auto pulses; disp_data 0xA then 0xB with disp_pid = 3; flush_done with done_pid = 3; pending returns to 0.
- Round-robin: flush pids 5, 1 and 9 in the same window, len 1 each, after a prior service of pid 5.
  - Required: service order 9, 1, 5; the pending bitmap decrements accordingly.
- Backpressure: disp_ready held low 20 cycles during SEND.
  - Required: disp_valid and disp_data stable all 20 cycles; no extra auto pulse; word delivered once when ready rises.
- Boundaries:
  - len 0 on pid 2: flush_done within 3 cycles, no auto.
  - len 2000 on pid 0: clamps to 1024 words; last adress = 1023.
  - Duplicate flush_req for a pending pid: ignored.
  - flush_pid = 11: ignored.
- Reset mid-flush: assert reset during SEND of word 1 of 4.
  - Required: all outputs 0 asynchronously, pending = 0, no flush_done.
  - After release, a new flush of pid 0 is serviced normally.
- Timeout (OUTSCHED_TIMEOUT_EN, TIMEOUT_CYCLES = 8), disp_ready stuck low:
  - Required: each word is dropped after 8 cycles; timeout_err = 1; flush_done still issued; timeout_err stays 1 until reset.
